// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register-file write port between
//            the ALU writeback (A) and the load return (M), with a registered
//            write port and a pending-destination scoreboard for hazard stalls.
// Options  : REGFILE_WB_FWD_EN adds fwd_valid/fwd_adr/fwd_data bypass outputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [AW-1:0]     a_adr,
   input  logic [DW-1:0]     a_data,
   input  logic              m_valid,
   output logic              m_ready,
   input  logic [AW-1:0]     m_adr,
   input  logic [DW-1:0]     m_data,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_adr,
   output logic              wr_en,
   output logic [AW-1:0]     wr_adr,
   output logic [DW-1:0]     wr_data,
   output logic              wr_src_m,
   output logic [2**AW-1:0]  pend_mask
`ifdef REGFILE_WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [AW-1:0]     fwd_adr,
   output logic [DW-1:0]     fwd_data
`endif
);

   localparam int c_NREG = 2**AW;

   // Last-grant pointer: the requester that won the most recent transfer.
   typedef enum logic {
      LP_A = 1'b0,
      LP_M = 1'b1
   } lp_t;

   lp_t               r_lp;
   logic              r_wr_en;
   logic [AW-1:0]     r_wr_adr;
   logic [DW-1:0]     r_wr_data;
   logic              r_wr_src_m;
   logic [c_NREG-1:0] r_pend;

   logic              w_a_ready;
   logic              w_m_ready;
   logic              w_xfer;
   logic [AW-1:0]     w_sel_adr;
   logic [DW-1:0]     w_sel_data;
   logic              w_sel_nz;
   logic [c_NREG-1:0] w_pend_next;

   // Grant: a lone requester always wins; on a tie the one not granted last wins.
   always_comb begin
      w_a_ready  = a_valid & (~m_valid | (r_lp == LP_M));
      w_m_ready  = m_valid & (~a_valid | (r_lp == LP_A));
      w_xfer     = w_a_ready | w_m_ready;
      w_sel_adr  = w_m_ready ? m_adr  : a_adr;
      w_sel_data = w_m_ready ? m_data : a_data;
      w_sel_nz   = (w_sel_adr != '0);
   end

   // Register the granted write; register 0 updates adr/data but never enables.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lp       <= LP_M;
         r_wr_en    <= 1'b0;
         r_wr_adr   <= '0;
         r_wr_data  <= '0;
         r_wr_src_m <= 1'b0;
      end else if (w_xfer) begin
         r_lp       <= w_m_ready ? LP_M : LP_A;
         r_wr_en    <= w_sel_nz;
         r_wr_adr   <= w_sel_adr;
         r_wr_data  <= w_sel_data;
         r_wr_src_m <= w_m_ready;
      end else begin
         r_wr_en    <= 1'b0;
      end
   end

   // Scoreboard next state: writeback clears, issue sets afterwards so it wins.
   always_comb begin
      w_pend_next = r_pend;
      if (r_wr_en) begin
         w_pend_next[r_wr_adr] = 1'b0;
      end
      if (iss_valid && (iss_adr != '0)) begin
         w_pend_next[iss_adr] = 1'b1;
      end
      w_pend_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_next;
      end
   end

   assign a_ready   = w_a_ready;
   assign m_ready   = w_m_ready;
   assign wr_en     = r_wr_en;
   assign wr_adr    = r_wr_adr;
   assign wr_data   = r_wr_data;
   assign wr_src_m  = r_wr_src_m;
   assign pend_mask = r_pend;

`ifdef REGFILE_WB_FWD_EN
   // Bypass view of the write that will land on the port next cycle.
   assign fwd_valid = w_xfer & w_sel_nz;
   assign fwd_adr   = w_sel_adr;
   assign fwd_data  = w_sel_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic            clk;
   logic            reset_n;
   logic            a_valid, m_valid, iss_valid;
   logic            a_ready, m_ready;
   logic [AW-1:0]   a_adr, m_adr, iss_adr;
   logic [DW-1:0]   a_data, m_data;
   logic            wr_en, wr_src_m;
   logic [AW-1:0]   wr_adr;
   logic [DW-1:0]   wr_data;
   logic [31:0]     pend_mask;
`ifdef REGFILE_WB_FWD_EN
   logic            fwd_valid;
   logic [AW-1:0]   fwd_adr;
   logic [DW-1:0]   fwd_data;
`endif

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_adr     (a_adr),
      .a_data    (a_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_adr     (m_adr),
      .m_data    (m_data),
      .iss_valid (iss_valid),
      .iss_adr   (iss_adr),
      .wr_en     (wr_en),
      .wr_adr    (wr_adr),
      .wr_data   (wr_data),
      .wr_src_m  (wr_src_m),
      .pend_mask (pend_mask)
`ifdef REGFILE_WB_FWD_EN
      ,
      .fwd_valid (fwd_valid),
      .fwd_adr   (fwd_adr),
      .fwd_data  (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tie sequence tables: grant order A,M,A,M with destinations 1..4.
   logic [AW-1:0] exp_adr [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
   logic          exp_m   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      reset_n = 1'b0;
      a_valid = 1'b0; a_adr = '0; a_data = '0;
      m_valid = 1'b0; m_adr = '0; m_data = '0;
      iss_valid = 1'b0; iss_adr = '0;
      #12;
      check("rst_wr_en",   wr_en,     0);
      check("rst_wr_adr",  wr_adr,    0);
      check("rst_wr_data", wr_data,   0);
      check("rst_src_m",   wr_src_m,  0);
      check("rst_pend",    pend_mask, 0);
      check("rst_ready",   {a_ready, m_ready}, 0);
      reset_n = 1'b1;
      tick();

      // A only -> one-cycle latency write
      a_valid = 1'b1; a_adr = 5'd5; a_data = 32'hDEADBEEF;
      #1;
      check("t1_a_ready", a_ready, 1);
      check("t1_m_ready", m_ready, 0);
`ifdef REGFILE_WB_FWD_EN
      check("t1_fwd", {fwd_valid, fwd_adr, fwd_data}, {1'b1, 5'd5, 32'hDEADBEEF});
`endif
      tick();
      a_valid = 1'b0;
      check("t1_wr_en",   wr_en,    1);
      check("t1_wr_adr",  wr_adr,   5);
      check("t1_wr_data", wr_data,  32'hDEADBEEF);
      check("t1_src_m",   wr_src_m, 0);
      tick();
      check("t1_wr_en_off", wr_en,  0);
      check("t1_hold_adr",  wr_adr, 5);
      check("t1_hold_data", wr_data, 32'hDEADBEEF);

      // Issue 7, then M writes 7 -> scoreboard set then cleared
      iss_valid = 1'b1; iss_adr = 5'd7;
      #1;
      check("t3_pend_pre", pend_mask, 0);
      tick();
      iss_valid = 1'b0;
      check("t3_pend_set", pend_mask, 32'h0000_0080);
      m_valid = 1'b1; m_adr = 5'd7; m_data = 32'h0000_1234;
      #1;
      check("t3_m_ready", m_ready, 1);
      check("t3_a_ready", a_ready, 0);
      tick();
      m_valid = 1'b0;
      check("t3_wr", {wr_en, wr_src_m, wr_adr, wr_data}, {1'b1, 1'b1, 5'd7, 32'h0000_1234});
      check("t3_pend_still", pend_mask, 32'h0000_0080);
      tick();
      check("t3_pend_clr", pend_mask, 0);
      check("t3_wr_en_off", wr_en, 0);

      // Ties: last grant was M, so A, M, A, M
      a_valid = 1'b1; a_adr = 5'd1; a_data = 32'hA000_0001;
      m_valid = 1'b1; m_adr = 5'd2; m_data = 32'hB000_0002;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_a_ready", a_ready, !exp_m[i]);
         check("t2_m_ready", m_ready, exp_m[i]);
         check("t2_excl", a_ready & m_ready, 0);
         tick();
         check("t2_wr_en",   wr_en,    1);
         check("t2_wr_adr",  wr_adr,   exp_adr[i]);
         check("t2_wr_data", wr_data,
               {(exp_m[i] ? 4'hB : 4'hA), 23'd0, exp_adr[i]});
         check("t2_src_m",   wr_src_m, exp_m[i]);
         case (i)
            0: begin a_adr = 5'd3; a_data = 32'hA000_0003; end
            1: begin m_adr = 5'd4; m_data = 32'hB000_0004; end
            2: begin a_adr = 5'd5; a_data = 32'hA000_0005; end
            default: m_valid = 1'b0;
         endcase
      end
      #1;
      check("t2_a_solo", a_ready, 1);
      tick();
      a_valid = 1'b0;
      check("t2_tail", {wr_en, wr_adr, wr_data}, {1'b1, 5'd5, 32'hA000_0005});
      tick();
      check("t2_idle", wr_en, 0);

      // Same-cycle clear and set on 9 -> set wins
      a_valid = 1'b1; a_adr = 5'd9; a_data = 32'h0000_0009;
      tick();
      a_valid = 1'b0;
      check("t4_wr_en9", {wr_en, wr_adr}, {1'b1, 5'd9});
      iss_valid = 1'b1; iss_adr = 5'd9;
      tick();
      iss_valid = 1'b0;
      check("t4_set_wins", pend_mask, 32'h0000_0200);
      // Clear 9 while setting 12 -> both apply
      a_valid = 1'b1; a_adr = 5'd9;
      tick();
      a_valid = 1'b0;
      check("t4_wr_en9b", wr_en, 1);
      iss_valid = 1'b1; iss_adr = 5'd12;
      tick();
      iss_valid = 1'b0;
      check("t4_clr_set", pend_mask, 32'h0000_1000);
      m_valid = 1'b1; m_adr = 5'd12; m_data = 32'h0000_000C;
      tick();
      m_valid = 1'b0;
      tick();
      check("t4_clr12", pend_mask, 0);

      // Register 0: accepted, no write enable, no scoreboard bit
      a_valid = 1'b1; a_adr = 5'd0; a_data = 32'h0000_5A5A;
      iss_valid = 1'b1; iss_adr = 5'd0;
      #1;
      check("t5_a_ready", a_ready, 1);
`ifdef REGFILE_WB_FWD_EN
      check("t5_fwd_valid", fwd_valid, 0);
`endif
      tick();
      a_valid = 1'b0; iss_valid = 1'b0;
      check("t5_wr_en", wr_en, 0);
      check("t5_wr_adr_data", {wr_adr, wr_data}, {5'd0, 32'h0000_5A5A});
      check("t5_pend", pend_mask, 0);
      // lp moved to A on the reg-0 transfer, so M wins this tie
      a_valid = 1'b1; a_adr = 5'd3; a_data = 32'hA000_0003;
      m_valid = 1'b1; m_adr = 5'd4; m_data = 32'hB000_0004;
      iss_valid = 1'b1; iss_adr = 5'd6;
      #1;
      check("t5_tie", {a_ready, m_ready}, 2'b01);

      // Asynchronous reset after an accepted transfer
      tick();
      a_valid = 1'b0; m_valid = 1'b0; iss_valid = 1'b0;
      check("t6_pre", {wr_en, wr_src_m, wr_adr}, {1'b1, 1'b1, 5'd4});
      check("t6_pre_pend", pend_mask, 32'h0000_0040);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_wr_en",   wr_en,     0);
      check("t6_wr_adr",  wr_adr,    0);
      check("t6_wr_data", wr_data,   0);
      check("t6_src_m",   wr_src_m,  0);
      check("t6_pend",    pend_mask, 0);
      #2;
      reset_n = 1'b1;
      a_valid = 1'b1; a_adr = 5'd10; a_data = 32'hA000_000A;
      m_valid = 1'b1; m_adr = 5'd11; m_data = 32'hB000_000B;
      #1;
      check("t6_tie_a", {a_ready, m_ready}, 2'b10);
      tick();
      a_valid = 1'b0; m_valid = 1'b0;
      check("t6_wr", {wr_en, wr_src_m, wr_adr}, {1'b1, 1'b0, 5'd10});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
